playseq_detector_jogada: RTL
============================

# playseq_detector_jogada

Input-side block of PlaySeq: turns raw, bouncing player buttons into the clean one-cycle `tem_jogada` strobe and stable one-hot `jogada` code that the game control unit and datapath consume during the `espera` phase. It sits between the board push-buttons and the datapath's jogada register. Each physical press produces exactly one strobe, after debounce and after the previous press was released. Multi-button presses are rejected.

## Interface
- `NBOTOES`, 4: number of buttons, which is also the width of `jogada`.
- `DEBOUNCE_CICLOS`, 50000: stable cycles required before accepting a press or a release; must be ≥2. The counter width is `$clog2(DEBOUNCE_CICLOS)`.

- `clock`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `botoes`  in  NBOTOES  raw asynchronous button levels, 1 = pressed.
- `habilita`  in  1  1 = control unit accepts plays. Driven high during the `espera` phase.
- `jogada`  out  NBOTOES  last accepted one-hot code. Held until the next accepted press.
- `tem_jogada`  out  1  one-cycle strobe when `jogada` is updated.
- `erro_multiplo`  out  1  one-cycle strobe when a stable press has more than one bit set.
- `db_estado`  out  3  current FSM state encoding, for the display.

## Operation
- Input stage: two-flop synchronizer gives `sinc`, or a direct path; see Configuration.
- FSM states:
  - OCIOSO=0: if `habilita` and `sinc`≠0, go to FILTRA, set `amostra`←`sinc` and `cont`←0.
  - FILTRA=1: if `sinc`≠`amostra` or `habilita`=0, go to OCIOSO (bounce or abort). Else if `cont`=DEBOUNCE_CICLOS−1, go to VALIDA. Else `cont`++.
  - VALIDA=2: if `amostra` has exactly one bit set, set `jogada`←`amostra` and go to PULSO. Otherwise pulse `erro_multiplo` and go to ESPERA_SOLTA.
  - PULSO=3: `tem_jogada`=`habilita`, so the strobe is suppressed if enable dropped. Go to ESPERA_SOLTA.
  - ESPERA_SOLTA=4: when `sinc`=0, go to FILTRA_SOLTA with `cont`←0.
  - FILTRA_SOLTA=5: if `sinc`≠0, go to ESPERA_SOLTA. Else if `cont`=DEBOUNCE_CICLOS−1, go to OCIOSO. Else `cont`++.
  - Encodings 6 and 7 are unreachable and go to OCIOSO.
- A held button never re-triggers. A new press is only considered after a debounced release.
- `habilita` low in ESPERA_SOLTA or FILTRA_SOLTA does not abort those states. Release tracking continues.
- `jogada` is updated only in VALIDA with a one-hot value. It is never cleared except by reset.
- `tem_jogada` and `erro_multiplo` are never high in the same cycle.

## Timing
- Reset (`reset`=0 at a rising edge) sets:
  - state=OCIOSO, `cont`=0, synchronizer flops=0, `amostra`=0;
  - outputs: `jogada`=0, `tem_jogada`=0, `erro_multiplo`=0, `db_estado`=0.
- Reset mid-operation (any state) takes effect at that same edge. No strobe follows.
- Press latency, with D = DEBOUNCE_CICLOS:
  - Let the first edge that samples a stable nonzero `botoes` be edge k.
  - With the synchronizer: FILTRA is entered at edge k+2, VALIDA at k+2+D, PULSO at k+3+D.
  - `tem_jogada` is high for exactly the cycle after edge k+3+D. `jogada` is valid from that same cycle.
- `erro_multiplo` is asserted in the VALIDA cycle, i.e. after edge k+2+D.
- Release latency: OCIOSO is re-entered D+1 cycles after ESPERA_SOLTA first sees `sinc`=0, provided there is no further bounce.
- Outputs are Moore-style from registered state and registers. There are no combinational paths from `botoes` to outputs.

## Configuration
- `PLAYSEQ_SINCRONIZADOR_EN` defined: two-flop synchronizer on `botoes`, with the latencies above.
- Not defined: `sinc`=`botoes` directly. All latencies are 2 cycles shorter: FILTRA is entered at edge k, and `tem_jogada` is high in the cycle after edge k+1+D. Intended for simulation with synchronous stimulus only.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4, NBOTOES=4, `habilita`=1 and the macro defined, unless stated.
- Clean press: `botoes`=0100 held 20 cycles from edge k -> a single `tem_jogada` in the cycle after edge k+7. `jogada`=0100 then and afterwards. `erro_multiplo` stays 0.
- Bounce: 0100 for 2 cycles, 0000 for 1 cycle, then 0100 held (stable from edge m) -> exactly one strobe, after edge m+7, with `jogada`=0100.
- Multiple press: 0101 held 20 cycles -> one `erro_multiplo` pulse after edge k+6, no `tem_jogada`, `jogada` keeps its previous value.
- Hold, release, re-press:
  - 0010 held 100 cycles -> one strobe only.
  - Release for 2 cycles, then 0001 -> no strobe; the release filter restarts.
  - Release held ≥6 cycles, then 0001 -> second strobe with `jogada`=0001.
- Enable and reset:
  - `habilita`=0 with 1000 held -> no strobe and state stays OCIOSO.
  - `reset`=0 for one edge during FILTRA -> next cycle all outputs 0 and `db_estado`=0.
- Macro undefined: clean press of 1000 from edge k -> strobe in the cycle after edge k+5.

Source files
------------

// File: rtl/playseq_detector_jogada_if.sv
// Signal bundle between the player buttons/control unit and the jogada detector.
// master = button/control side, slave = detector.
interface playseq_detector_jogada_if #(
  parameter int NBOTOES = 4
);
  logic [NBOTOES-1:0] botoes;
  logic               habilita;
  logic [NBOTOES-1:0] jogada;
  logic               tem_jogada;
  logic               erro_multiplo;
  logic [2:0]         db_estado;

  modport master (
    output botoes, habilita,
    input  jogada, tem_jogada, erro_multiplo, db_estado
  );

  modport slave (
    input  botoes, habilita,
    output jogada, tem_jogada, erro_multiplo, db_estado
  );
endinterface

// File: rtl/playseq_detector_jogada.sv
// Debounced one-hot play detector: one tem_jogada strobe per physical press.
// Optional input synchronizer enabled by PLAYSEQ_SINCRONIZADOR_EN.
//
// state        | meaning
// OCIOSO       | waiting for a nonzero press while habilita is high
// FILTRA       | press must stay identical for DEBOUNCE_CICLOS edges
// VALIDA       | accept one-hot press or flag multi-button press
// PULSO        | tem_jogada strobe cycle
// ESPERA_SOLTA | waiting for all buttons released
// FILTRA_SOLTA | release must stay stable for DEBOUNCE_CICLOS edges
module playseq_detector_jogada #(
  parameter int NBOTOES         = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input logic                     clock,
  input logic                     reset,
  playseq_detector_jogada_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA       = 3'd1,
    VALIDA       = 3'd2,
    PULSO        = 3'd3,
    ESPERA_SOLTA = 3'd4,
    FILTRA_SOLTA = 3'd5
  } estado_t;

  estado_t            estado;
  logic [CW-1:0]      cont;
  logic [NBOTOES-1:0] amostra;
  logic [NBOTOES-1:0] jogada_r;
  logic               tem_r;
  logic               erro_r;
  logic [NBOTOES-1:0] sinc;

`ifdef PLAYSEQ_SINCRONIZADOR_EN
  logic [NBOTOES-1:0] sinc_meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sinc_meta <= '0;
      sinc      <= '0;
    end else begin
      sinc_meta <= bus.botoes;
      sinc      <= sinc_meta;
    end
  end
`else
  assign sinc = bus.botoes;
`endif

  // Strobes are registered one edge ahead so they line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      cont     <= '0;
      amostra  <= '0;
      jogada_r <= '0;
      tem_r    <= 1'b0;
      erro_r   <= 1'b0;
    end else begin
      tem_r  <= 1'b0;
      erro_r <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.habilita && (sinc != '0)) begin
            estado  <= FILTRA;
            amostra <= sinc;
            cont    <= '0;
          end
        end
        FILTRA: begin
          if ((sinc != amostra) || !bus.habilita) begin
            estado <= OCIOSO;
          end else if (cont == CONT_MAX) begin
            estado <= VALIDA;
            erro_r <= !$onehot(amostra);
          end else begin
            cont <= cont + 1'b1;
          end
        end
        VALIDA: begin
          if ($onehot(amostra)) begin
            jogada_r <= amostra;
            tem_r    <= bus.habilita;
            estado   <= PULSO;
          end else begin
            estado <= ESPERA_SOLTA;
          end
        end
        PULSO: begin
          estado <= ESPERA_SOLTA;
        end
        ESPERA_SOLTA: begin
          if (sinc == '0) begin
            estado <= FILTRA_SOLTA;
            cont   <= '0;
          end
        end
        FILTRA_SOLTA: begin
          if (sinc != '0) begin
            estado <= ESPERA_SOLTA;
          end else if (cont == CONT_MAX) begin
            estado <= OCIOSO;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.jogada        = jogada_r;
  assign bus.tem_jogada    = tem_r;
  assign bus.erro_multiplo = erro_r;
  assign bus.db_estado     = estado;

endmodule
